adc_capture_sequencer: RTL and testbench
========================================

# adc_capture_sequencer

Sequences the ADC DPRAM capture controller from CPU CSRs. It arms a burst of 1..255 captures. Each capture waits for a trigger: immediate, software, or a level crossing on ADC ch0. The block then issues a one-cycle start pulse to the capture controller, waits for that capture's done, and applies a programmable holdoff before re-arming. It sits between the CSR bank and the capture controller, and provides trigger timeout, abort and burst status to the CPU.

## Interface
Parameters:
- COUNT_W, 8, burst counter width.
- HOLDOFF_W, 24, holdoff counter width in sys_clk cycles.
- TIMEOUT_W, 28, trigger-wait timeout counter width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset; asynchronous assert, active-low.
- csr_arm_i  in  1  level; rising edge starts a burst. Ignored unless IDLE.
- csr_abort_i  in  1  level; rising edge aborts the burst.
- csr_sw_trig_i  in  1  level; rising edge is the software trigger (mode 1 only).
- csr_trig_mode_i  in  2  0 immediate, 1 software, 2 ch0 rising-crossing, 3 ch0 falling-crossing.
- csr_trig_level_i  in  16  signed threshold for ch0.
- csr_burst_count_i  in  COUNT_W  captures per burst; 0 is treated as 1.
- csr_holdoff_i  in  HOLDOFF_W  cycles between a capture's done and the next trigger wait.
- csr_timeout_i  in  TIMEOUT_W  max cycles spent in WAIT_TRIG; 0 disables the timeout.
- adc_sample_in  in  adc_sample_t  live ADC sample; [15:0] is ch0 (signed).
- cap_start_o  out  1  registered one-cycle start pulse to the capture controller.
- cap_done_i  in  1  capture-controller done flag, level and sticky.
- csr_busy_o  out  1  high in every state except IDLE.
- csr_done_o  out  1  sticky; burst completed normally.
- csr_timeout_o  out  1  sticky; trigger wait expired.
- csr_aborted_o  out  1  sticky; burst ended by abort.
- csr_captures_o  out  COUNT_W  captures completed in the current or last burst.
- csr_state_o  out  3  current state encoding.
- irq_o  out  1  one-cycle pulse whenever the block returns to IDLE from a non-IDLE state.

## Operation
- States: IDLE, WAIT_TRIG, START, CAPTURE, HOLDOFF, DRAIN.
- Rising edges of arm, abort, sw_trig and cap_done are detected against 1-cycle-delayed copies of each signal.
- IDLE, on arm edge:
  - Latch mode, level, burst_count, holdoff and timeout into shadow registers.
  - Clear done, timeout, aborted and captures.
  - Go to WAIT_TRIG.
- WAIT_TRIG: the timeout counter and the trigger history are cleared on every entry.
  - Mode 0: trigger fires on the first WAIT_TRIG cycle.
  - Mode 1: trigger fires on a sw_trig edge.
  - Mode 2: fires when prev_ch0 < level and cur_ch0 >= level.
  - Mode 3: fires when prev_ch0 > level and cur_ch0 <= level.
  - Modes 2/3 need one valid prev sample, so they cannot fire on the entry cycle.
  - Trigger → START.
- WAIT_TRIG timeout: if timeout is nonzero and the counter reaches timeout-1 with no trigger, set csr_timeout_o and go to IDLE.
- START: cap_start_o=1 for exactly this cycle, then CAPTURE.
- CAPTURE: waits for a cap_done_i rising edge.
  - A stale high done from a previous capture does not count.
  - On the edge, captures++.
  - If captures+1 == burst_count: set csr_done_o, go to IDLE.
  - Otherwise go to HOLDOFF, or straight to WAIT_TRIG if holdoff == 0.
- HOLDOFF: counts holdoff cycles, then goes to WAIT_TRIG.
- Abort edge in WAIT_TRIG, HOLDOFF or START: set aborted, go to IDLE.
  - In START, the pulse in progress still completes; the sequencer then goes to DRAIN instead of IDLE.
- Abort edge in CAPTURE: go to DRAIN. The capture controller cannot be stopped mid-buffer.
- DRAIN: wait for the cap_done edge, set aborted, go to IDLE. That capture is not counted.
- Simultaneous events:
  - Abort wins over trigger, timeout and done in the same cycle. A done edge coinciding with an abort in CAPTURE still goes to DRAIN→IDLE, next cycle.
  - Trigger wins over timeout in the same cycle.
- csr_captures_o saturates at burst_count; it does not wrap.
- Reset mid-operation:
  - All outputs and state go to 0 / IDLE immediately.
  - A capture controller already running is not stopped. Its later done edge is ignored because the block is in IDLE.

## Timing
- Reset values: every output is 0; state is IDLE; all counters and shadow registers are 0.
- Arm edge at cycle N → WAIT_TRIG at N+1.
- Mode 0: START at N+2; cap_start_o high in cycle N+2 only.
- Trigger condition seen at cycle T → cap_start_o high at T+1.
- cap_done_i rise at cycle D → edge detected at D → next state takes effect at D+1.
  - For the last capture, csr_done_o and irq_o are high at D+1.
- Holdoff H > 0 → WAIT_TRIG entered exactly H cycles after HOLDOFF is entered.
- Timeout TO → WAIT_TRIG lasts exactly TO cycles before IDLE.
- All outputs are registered. csr_state_o reflects the current state.

## Structure
- signal_types_pkg gains the following types:
  - seq_state_t: 3-bit enum, IDLE=0, WAIT_TRIG=1, START=2, CAPTURE=3, HOLDOFF=4, DRAIN=5.
  - trig_mode_t: 2-bit enum, values as in Interface.
- It also gains the existing adc_sample_t accessor for ch0.
- One sub-module, adc_trigger_detect, holds the prev_ch0 register, the history-valid flag, the signed compare and the mode mux. Its outputs are trig_o and a clear input for history.
- The rest of the block is a single FSM plus three counters: holdoff, timeout and captures.

## Test plan
- Mode 0, burst=3, holdoff=10; done driven 20 cycles after each start → three cap_start_o pulses spaced 20+10+1 cycles apart; captures=3; done=1; one irq.
- Mode 2, level=0x0100; ch0 ramps 0x00F0→0x0110 in steps of 8 → start pulse exactly 1 cycle after the sample reaches ≥0x0100; no trigger from a sample already above level on the entry cycle.
- Mode 1, timeout=50, no sw_trig → state returns to IDLE after 50 WAIT_TRIG cycles; timeout=1; done=0; cap_start_o never asserted.
- Abort edge during CAPTURE → state DRAIN; done pulsed 100 cycles later → IDLE; aborted=1; captures unchanged; no further start pulses.
- cap_done_i held high from a prior capture when a new burst starts → no false completion; only a fresh 0→1 edge counts.
- sys_rst_n asserted in HOLDOFF; arm, sw_trig and level trigger events applied during reset → every output 0 in the same cycle as assertion; no start pulse after release until a new arm edge.

Source files
------------

// File: rtl/signal_types_pkg.sv
// Shared ADC-side types: sample layout, capture-sequencer states and trigger modes.
package signal_types_pkg;

    typedef struct packed {
        logic signed [15:0] ch1;
        logic signed [15:0] ch0;
    } adc_sample_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TRIG = 3'd1,
        START     = 3'd2,
        CAPTURE   = 3'd3,
        HOLDOFF   = 3'd4,
        DRAIN     = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        TRIG_IMMEDIATE = 2'd0,
        TRIG_SOFTWARE  = 2'd1,
        TRIG_RISING    = 2'd2,
        TRIG_FALLING   = 2'd3
    } trig_mode_t;

    function automatic logic signed [15:0] adc_ch0(input adc_sample_t s);
        return s.ch0;
    endfunction

endpackage

// File: rtl/adc_trigger_detect.sv
// Trigger qualifier for the capture sequencer: ch0 level crossing with one-sample history.
module adc_trigger_detect
    import signal_types_pkg::*;
(
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               clear,
    input  logic               sw_edge,
    input  trig_mode_t         mode,
    input  logic signed [15:0] level,
    input  adc_sample_t        sample,
    output logic               trig_o
);

    logic signed [15:0] cur_ch0;
    logic signed [15:0] prev_ch0;
    logic               hist_valid;
    logic               unused_ch1;

    assign cur_ch0    = adc_ch0(sample);
    assign unused_ch1 = ^sample.ch1;

    // History is held cleared outside the trigger wait, so the entry cycle never has a prev sample.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_ch0   <= '0;
            hist_valid <= 1'b0;
        end else if (clear) begin
            prev_ch0   <= '0;
            hist_valid <= 1'b0;
        end else begin
            prev_ch0   <= cur_ch0;
            hist_valid <= 1'b1;
        end
    end

    always_comb begin
        trig_o = 1'b0;
        case (mode)
            TRIG_IMMEDIATE: trig_o = 1'b1;
            TRIG_SOFTWARE:  trig_o = sw_edge;
            TRIG_RISING:    trig_o = hist_valid && (prev_ch0 < level) && (cur_ch0 >= level);
            TRIG_FALLING:   trig_o = hist_valid && (prev_ch0 > level) && (cur_ch0 <= level);
            default:        trig_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/adc_capture_sequencer.sv
// Burst capture sequencer: arms from CSRs, waits for a trigger, pulses the capture
// controller, waits for its done and applies holdoff, with timeout and abort handling.
module adc_capture_sequencer
    import signal_types_pkg::*;
#(
    parameter int unsigned COUNT_W   = 8,
    parameter int unsigned HOLDOFF_W = 24,
    parameter int unsigned TIMEOUT_W = 28
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic                 csr_arm_i,
    input  logic                 csr_abort_i,
    input  logic                 csr_sw_trig_i,
    input  logic [1:0]           csr_trig_mode_i,
    input  logic [15:0]          csr_trig_level_i,
    input  logic [COUNT_W-1:0]   csr_burst_count_i,
    input  logic [HOLDOFF_W-1:0] csr_holdoff_i,
    input  logic [TIMEOUT_W-1:0] csr_timeout_i,
    input  adc_sample_t          adc_sample_in,
    output logic                 cap_start_o,
    input  logic                 cap_done_i,
    output logic                 csr_busy_o,
    output logic                 csr_done_o,
    output logic                 csr_timeout_o,
    output logic                 csr_aborted_o,
    output logic [COUNT_W-1:0]   csr_captures_o,
    output logic [2:0]           csr_state_o,
    output logic                 irq_o
);

    seq_state_t state, next_state;

    logic arm_d, abort_d, sw_d, done_d;
    logic arm_edge, abort_edge, sw_edge, done_edge;

    trig_mode_t           mode_q;
    logic signed [15:0]   level_q;
    logic [COUNT_W-1:0]   burst_q;
    logic [HOLDOFF_W-1:0] holdoff_q;
    logic [TIMEOUT_W-1:0] timeout_q;

    logic [HOLDOFF_W-1:0] hold_cnt;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic                 drain_done_q;

    logic trig;
    logic last_capture;
    logic load_shadow, set_done, set_timeout, set_aborted, count_capture, drain_note;

    assign arm_edge   = csr_arm_i & ~arm_d;
    assign abort_edge = csr_abort_i & ~abort_d;
    assign sw_edge    = csr_sw_trig_i & ~sw_d;
    assign done_edge  = cap_done_i & ~done_d;

    assign last_capture = (csr_captures_o + COUNT_W'(1)) == burst_q;

    assign cap_start_o = (state == START);
    assign csr_busy_o  = (state != IDLE);
    assign csr_state_o = state;

    adc_trigger_detect u_trig (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clear     (state != WAIT_TRIG),
        .sw_edge   (sw_edge),
        .mode      (mode_q),
        .level     (level_q),
        .sample    (adc_sample_in),
        .trig_o    (trig)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state    = state;
        load_shadow   = 1'b0;
        set_done      = 1'b0;
        set_timeout   = 1'b0;
        set_aborted   = 1'b0;
        count_capture = 1'b0;
        drain_note    = 1'b0;
        case (state)
            IDLE: begin
                if (arm_edge) begin
                    load_shadow = 1'b1;
                    next_state  = WAIT_TRIG;
                end
            end
            WAIT_TRIG: begin
                if (abort_edge) begin
                    set_aborted = 1'b1;
                    next_state  = IDLE;
                end else if (trig) begin
                    next_state = START;
                end else if ((timeout_q != '0) && (tmo_cnt == timeout_q - TIMEOUT_W'(1))) begin
                    set_timeout = 1'b1;
                    next_state  = IDLE;
                end
            end
            START: begin
                next_state = abort_edge ? DRAIN : CAPTURE;
            end
            CAPTURE: begin
                // A done edge coinciding with abort is remembered so DRAIN exits on the next cycle.
                if (abort_edge) begin
                    next_state = DRAIN;
                    drain_note = done_edge;
                end else if (done_edge) begin
                    count_capture = 1'b1;
                    if (last_capture) begin
                        set_done   = 1'b1;
                        next_state = IDLE;
                    end else if (holdoff_q == '0) begin
                        next_state = WAIT_TRIG;
                    end else begin
                        next_state = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (abort_edge) begin
                    set_aborted = 1'b1;
                    next_state  = IDLE;
                end else if (hold_cnt == holdoff_q - HOLDOFF_W'(1)) begin
                    next_state = WAIT_TRIG;
                end
            end
            DRAIN: begin
                if (done_edge || drain_done_q) begin
                    set_aborted = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            arm_d          <= 1'b0;
            abort_d        <= 1'b0;
            sw_d           <= 1'b0;
            done_d         <= 1'b0;
            mode_q         <= TRIG_IMMEDIATE;
            level_q        <= '0;
            burst_q        <= '0;
            holdoff_q      <= '0;
            timeout_q      <= '0;
            hold_cnt       <= '0;
            tmo_cnt        <= '0;
            drain_done_q   <= 1'b0;
            csr_done_o     <= 1'b0;
            csr_timeout_o  <= 1'b0;
            csr_aborted_o  <= 1'b0;
            csr_captures_o <= '0;
            irq_o          <= 1'b0;
        end else begin
            arm_d   <= csr_arm_i;
            abort_d <= csr_abort_i;
            sw_d    <= csr_sw_trig_i;
            done_d  <= cap_done_i;

            if (load_shadow) begin
                mode_q         <= trig_mode_t'(csr_trig_mode_i);
                level_q        <= csr_trig_level_i;
                burst_q        <= (csr_burst_count_i == '0) ? COUNT_W'(1) : csr_burst_count_i;
                holdoff_q      <= csr_holdoff_i;
                timeout_q      <= csr_timeout_i;
                csr_done_o     <= 1'b0;
                csr_timeout_o  <= 1'b0;
                csr_aborted_o  <= 1'b0;
                csr_captures_o <= '0;
            end else begin
                if (set_done)    csr_done_o    <= 1'b1;
                if (set_timeout) csr_timeout_o <= 1'b1;
                if (set_aborted) csr_aborted_o <= 1'b1;
                if (count_capture && (csr_captures_o != burst_q))
                    csr_captures_o <= csr_captures_o + COUNT_W'(1);
            end

            tmo_cnt  <= (state == WAIT_TRIG) ? tmo_cnt + TIMEOUT_W'(1) : '0;
            hold_cnt <= (state == HOLDOFF) ? hold_cnt + HOLDOFF_W'(1) : '0;

            if (next_state != DRAIN) drain_done_q <= 1'b0;
            else if (drain_note)     drain_done_q <= 1'b1;

            irq_o <= (state != IDLE) && (next_state == IDLE);
        end
    end

endmodule

// File: tb/tb_adc_capture_sequencer.sv
// Directed self-checking bench for adc_capture_sequencer; expectations are hand-derived cycle counts.
module tb_adc_capture_sequencer;
    import signal_types_pkg::*;

    localparam int unsigned COUNT_W   = 8;
    localparam int unsigned HOLDOFF_W = 24;
    localparam int unsigned TIMEOUT_W = 28;

    logic                 sys_clk = 1'b0;
    logic                 sys_rst_n = 1'b0;
    logic                 csr_arm_i = 1'b0;
    logic                 csr_abort_i = 1'b0;
    logic                 csr_sw_trig_i = 1'b0;
    logic [1:0]           csr_trig_mode_i = '0;
    logic [15:0]          csr_trig_level_i = '0;
    logic [COUNT_W-1:0]   csr_burst_count_i = '0;
    logic [HOLDOFF_W-1:0] csr_holdoff_i = '0;
    logic [TIMEOUT_W-1:0] csr_timeout_i = '0;
    adc_sample_t          adc_sample_in = '0;
    logic                 cap_start_o;
    logic                 cap_done_i = 1'b0;
    logic                 csr_busy_o;
    logic                 csr_done_o;
    logic                 csr_timeout_o;
    logic                 csr_aborted_o;
    logic [COUNT_W-1:0]   csr_captures_o;
    logic [2:0]           csr_state_o;
    logic                 irq_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned start_count = 0;
    int unsigned irq_count = 0;
    int unsigned start_cyc[$];
    int unsigned sc;

    adc_capture_sequencer #(
        .COUNT_W   (COUNT_W),
        .HOLDOFF_W (HOLDOFF_W),
        .TIMEOUT_W (TIMEOUT_W)
    ) dut (
        .sys_clk           (sys_clk),
        .sys_rst_n         (sys_rst_n),
        .csr_arm_i         (csr_arm_i),
        .csr_abort_i       (csr_abort_i),
        .csr_sw_trig_i     (csr_sw_trig_i),
        .csr_trig_mode_i   (csr_trig_mode_i),
        .csr_trig_level_i  (csr_trig_level_i),
        .csr_burst_count_i (csr_burst_count_i),
        .csr_holdoff_i     (csr_holdoff_i),
        .csr_timeout_i     (csr_timeout_i),
        .adc_sample_in     (adc_sample_in),
        .cap_start_o       (cap_start_o),
        .cap_done_i        (cap_done_i),
        .csr_busy_o        (csr_busy_o),
        .csr_done_o        (csr_done_o),
        .csr_timeout_o     (csr_timeout_o),
        .csr_aborted_o     (csr_aborted_o),
        .csr_captures_o    (csr_captures_o),
        .csr_state_o       (csr_state_o),
        .irq_o             (irq_o)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (cap_start_o) begin
            start_count++;
            start_cyc.push_back(cyc);
        end
        if (irq_o) irq_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic set_ch0(input logic [15:0] v);
        adc_sample_in = '{ch1: 16'sh0000, ch0: v};
    endtask

    task automatic setup_csr(input logic [1:0] mode, input logic [15:0] level,
                             input logic [7:0] burst, input int unsigned holdoff,
                             input int unsigned timeout);
        csr_trig_mode_i   = mode;
        csr_trig_level_i  = level;
        csr_burst_count_i = burst;
        csr_holdoff_i     = HOLDOFF_W'(holdoff);
        csr_timeout_i     = TIMEOUT_W'(timeout);
    endtask

    // Arm edge sampled on the next clock; returns just after WAIT_TRIG is entered.
    task automatic arm();
        csr_arm_i = 1'b1;
        tick();
        csr_arm_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"},   32'(csr_state_o),    32'd0);
        check({tag, "_busy"},    32'(csr_busy_o),     32'd0);
        check({tag, "_start"},   32'(cap_start_o),    32'd0);
        check({tag, "_done"},    32'(csr_done_o),     32'd0);
        check({tag, "_timeout"}, 32'(csr_timeout_o),  32'd0);
        check({tag, "_aborted"}, 32'(csr_aborted_o),  32'd0);
        check({tag, "_capt"},    32'(csr_captures_o), 32'd0);
        check({tag, "_irq"},     32'(irq_o),          32'd0);
    endtask

    initial begin
        set_ch0(16'h0000);
        tick(2);
        check_all_zero("reset");
        sys_rst_n = 1'b1;
        tick(2);

        // Mode 0, burst 3, holdoff 10, done 20 cycles after each start.
        setup_csr(2'd0, 16'h0000, 8'd3, 10, 0);
        arm();
        check("t1_wait", 32'(csr_state_o), 32'd1);
        check("t1_busy", 32'(csr_busy_o), 32'd1);
        tick();
        check("t1_start0", 32'(cap_start_o), 32'd1);
        for (int k = 0; k < 3; k++) begin
            cap_done_i = 1'b0;
            tick(19);
            if (k == 0) check("t1_capture", 32'(csr_state_o), 32'd3);
            cap_done_i = 1'b1;
            tick();
            if (k < 2) begin
                check("t1_holdoff", 32'(csr_state_o), 32'd4);
                check("t1_capt_n", 32'(csr_captures_o), 32'(k + 1));
                tick(10);
                check("t1_rewait", 32'(csr_state_o), 32'd1);
                tick();
                check("t1_restart", 32'(cap_start_o), 32'd1);
            end else begin
                check("t1_idle", 32'(csr_state_o), 32'd0);
                check("t1_done", 32'(csr_done_o), 32'd1);
                check("t1_irq", 32'(irq_o), 32'd1);
                check("t1_capt", 32'(csr_captures_o), 32'd3);
            end
        end
        tick();
        check("t1_irq_pulse", 32'(irq_o), 32'd0);
        check("t1_nstart", start_count, 32'd3);
        if (start_cyc.size() == 3) begin
            check("t1_space1", start_cyc[1] - start_cyc[0], 32'd31);
            check("t1_space2", start_cyc[2] - start_cyc[1], 32'd31);
        end
        check("t1_nirq", irq_count, 32'd1);

        // Mode 2 rising crossing of 0x0100; the entry sample already sits above level.
        cap_done_i = 1'b0;
        set_ch0(16'h0120);
        setup_csr(2'd2, 16'h0100, 8'd1, 0, 0);
        arm();
        tick(3);
        check("t2_no_entry_trig", 32'(csr_state_o), 32'd1);
        set_ch0(16'h00F0);
        tick();
        set_ch0(16'h00F8);
        tick();
        check("t2_below", 32'(cap_start_o), 32'd0);
        set_ch0(16'h0100);
        tick();
        check("t2_cross", 32'(cap_start_o), 32'd1);
        set_ch0(16'h0108);
        tick(5);
        cap_done_i = 1'b1;
        tick();
        check("t2_idle", 32'(csr_state_o), 32'd0);
        check("t2_done", 32'(csr_done_o), 32'd1);
        check("t2_capt", 32'(csr_captures_o), 32'd1);

        // Mode 3 falling crossing to exactly the level.
        cap_done_i = 1'b0;
        set_ch0(16'h0110);
        setup_csr(2'd3, 16'h0100, 8'd1, 0, 0);
        arm();
        tick();
        check("t2f_hold", 32'(cap_start_o), 32'd0);
        set_ch0(16'h0100);
        tick();
        check("t2f_cross", 32'(cap_start_o), 32'd1);
        tick();
        cap_done_i = 1'b1;
        tick();
        check("t2f_idle", 32'(csr_state_o), 32'd0);

        // Mode 1 with timeout 50 and no software trigger.
        cap_done_i = 1'b0;
        setup_csr(2'd1, 16'h0000, 8'd1, 0, 50);
        sc = start_count;
        arm();
        tick(49);
        check("t3_still_wait", 32'(csr_state_o), 32'd1);
        tick();
        check("t3_idle", 32'(csr_state_o), 32'd0);
        check("t3_timeout", 32'(csr_timeout_o), 32'd1);
        check("t3_done", 32'(csr_done_o), 32'd0);
        check("t3_irq", 32'(irq_o), 32'd1);
        tick();
        check("t3_nostart", start_count, sc);

        // Mode 1 fired by a software trigger edge.
        setup_csr(2'd1, 16'h0000, 8'd1, 0, 0);
        arm();
        check("t3s_timeout_clr", 32'(csr_timeout_o), 32'd0);
        tick(3);
        check("t3s_wait", 32'(csr_state_o), 32'd1);
        csr_sw_trig_i = 1'b1;
        tick();
        check("t3s_start", 32'(cap_start_o), 32'd1);
        csr_sw_trig_i = 1'b0;
        tick();
        cap_done_i = 1'b1;
        tick();
        check("t3s_done", 32'(csr_done_o), 32'd1);

        // Abort during CAPTURE drains the in-flight buffer.
        cap_done_i = 1'b0;
        setup_csr(2'd0, 16'h0000, 8'd2, 0, 0);
        arm();
        tick(2);
        check("t4_capture", 32'(csr_state_o), 32'd3);
        sc = start_count;
        csr_abort_i = 1'b1;
        tick();
        check("t4_drain", 32'(csr_state_o), 32'd5);
        csr_abort_i = 1'b0;
        tick(99);
        check("t4_drain_hold", 32'(csr_state_o), 32'd5);
        cap_done_i = 1'b1;
        tick();
        check("t4_idle", 32'(csr_state_o), 32'd0);
        check("t4_aborted", 32'(csr_aborted_o), 32'd1);
        check("t4_capt", 32'(csr_captures_o), 32'd0);
        check("t4_done", 32'(csr_done_o), 32'd0);
        check("t4_irq", 32'(irq_o), 32'd1);
        tick(20);
        check("t4_nostart", start_count, sc);

        // Stale high done from the previous capture; burst 0 behaves as 1.
        setup_csr(2'd0, 16'h0000, 8'd0, 0, 0);
        arm();
        check("t5_abort_clr", 32'(csr_aborted_o), 32'd0);
        tick(12);
        check("t5_stale", 32'(csr_state_o), 32'd3);
        check("t5_stale_done", 32'(csr_done_o), 32'd0);
        cap_done_i = 1'b0;
        tick();
        cap_done_i = 1'b1;
        tick();
        check("t5_idle", 32'(csr_state_o), 32'd0);
        check("t5_done", 32'(csr_done_o), 32'd1);
        check("t5_capt", 32'(csr_captures_o), 32'd1);

        // Reset asserted in HOLDOFF with trigger stimulus applied during reset.
        cap_done_i = 1'b0;
        setup_csr(2'd0, 16'h0000, 8'd2, 100, 0);
        arm();
        tick(2);
        cap_done_i = 1'b1;
        tick();
        tick(5);
        check("t6_holdoff", 32'(csr_state_o), 32'd4);
        sc = start_count;
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        setup_csr(2'd2, 16'h0100, 8'd1, 0, 0);
        csr_arm_i = 1'b1;
        csr_sw_trig_i = 1'b1;
        set_ch0(16'h00F0);
        tick();
        set_ch0(16'h0110);
        tick(2);
        csr_arm_i = 1'b0;
        csr_sw_trig_i = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        tick(20);
        check("t6_post_idle", 32'(csr_state_o), 32'd0);
        check("t6_nostart", start_count, sc);
        cap_done_i = 1'b0;
        setup_csr(2'd0, 16'h0000, 8'd1, 0, 0);
        arm();
        tick();
        check("t6_rearm", 32'(cap_start_o), 32'd1);
        tick();
        cap_done_i = 1'b1;
        tick();
        check("t6_done", 32'(csr_done_o), 32'd1);
        tick(2);
        check("total_irq", irq_count, 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
